// File: rtl/omp_v_ctrl.sv
// omp_v_ctrl: stream-to-RAM controller in front of the omp_V single-port vector
// buffer (1-cycle read latency, write-first). LOAD writes len words from the
// s_* stream to addresses 0..len-1. DRAIN reads addresses 0..len-1 through a
// 2-entry skid FIFO onto the m_* stream with full backpressure.
//
// Optional feature: define OMP_V_CTRL_LEN_CHECK_EN to clamp len to MEM_SIZE and
// raise a sticky err. Without it, len is used as given, the address wraps and
// err is tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, mode, len       command (mode 0 = LOAD, 1 = DRAIN), sampled in IDLE
//   s_data/s_valid/s_ready load stream
//   m_data/m_valid/m_ready drain stream
//   busy, done, err        status (done is a one-cycle pulse)
//   ram_addr/ce/we/d, ram_q buffer port
module omp_v_ctrl #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AWIDTH   = 7,
  parameter int unsigned MEM_SIZE = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [AWIDTH:0]   len,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);

  localparam int unsigned CntW = AWIDTH + 1;
  localparam logic [AWIDTH:0] MemSizeW = CntW'(MEM_SIZE);

`ifdef OMP_V_CTRL_LEN_CHECK_EN
  localparam bit LenCheck = 1'b1;
`else
  localparam bit LenCheck = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH:0]   len_q, len_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;    // write address / issued reads
  logic [AWIDTH:0]   dcnt_q, dcnt_d;  // delivered words
  logic              err_q, err_d;

  // Skid FIFO
  logic [DWIDTH-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;
  logic              rd_pend_q;       // read issued last cycle, ram_q valid now
  logic              issue;
  logic              pop;
  logic [1:0]        slots;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = fifo_q[rd_ptr_q];
  assign pop      = m_valid && m_ready;
  assign busy     = (state_q != StIdle);
  assign ram_addr = cnt_q[AWIDTH-1:0];
  assign err      = LenCheck ? err_q : 1'b0;

  // Slots committed after this edge; a same-cycle pop frees one, which keeps
  // the read pipeline full at one word per cycle under m_ready=1.
  assign slots = occ_q + {1'b0, rd_pend_q} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    s_ready = 1'b0;
    ram_ce  = 1'b0;
    ram_we  = 1'b0;
    ram_d   = '0;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d  = '0;
          dcnt_d = '0;
          err_d  = 1'b0;
          len_d  = len;
          if (LenCheck && (len > MemSizeW)) begin
            len_d = MemSizeW;
            err_d = 1'b1;
          end
          if (len_d == '0) state_d = StFin;
          else             state_d = mode ? StDrain : StLoad;
        end
      end
      StLoad: begin
        s_ready = 1'b1;
        ram_ce  = s_valid;
        ram_we  = s_valid;
        ram_d   = s_data;
        if (s_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = StFin;
        end
      end
      StDrain: begin
        issue  = (cnt_q < len_q) && (slots < 2'd2);
        ram_ce = issue;
        if (issue) cnt_d = cnt_q + 1'b1;
        if (pop) begin
          dcnt_d = dcnt_q + 1'b1;
          if (dcnt_d == len_q) state_d = StFin;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      if (rd_pend_q) begin
        fifo_q[wr_ptr_q] <= ram_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

endmodule
